// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; clamped to 1 so a degenerate width still elaborates.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d0;
    logic b0;
    logic b1;

    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .diff (d0),
        .bout (b0)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs1 (
        .a    (d0),
        .b    (bin),
        .diff (diff),
        .bout (b1)
    );

    assign bout = b0 | b1;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: a - b with borrow-out.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first WIDTH-bit subtractor with start/busy/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bff_q, bff_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (bff_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        bff_d    = bff_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    bff_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {fs_diff, res_q[WIDTH-1:1]};
                bff_d = fs_bout;
                cnt_d = cnt_q + CNT_W'(1);
                // Last bit: publish the full result, including this cycle's bit.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = res_d;
                    borrow_d = fs_bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bff_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            bff_q    <= bff_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and exhaustive WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int errors;
    int checks;
    logic [7:0] exp_diff;
    logic       exp_borrow;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run one WIDTH=8 op. b2b: caller is already in the done cycle of the previous op.
    // hold: keep start high and scramble a/b during RUN; both must be ignored.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit b2b,
                        input bit hold, input logic [7:0] ed, input logic eb);
        if (!b2b) @(negedge clk);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(posedge clk);
        #1;
        if (hold) begin
            a8 = 8'd1;
            b8 = 8'd1;
        end else begin
            start8 = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy8_run", busy8, 1);
            check("done8_run", done8, 0);
            check("diff8_held", diff8, exp_diff);
            check("borrow8_held", borrow8, exp_borrow);
            if (i == 7) start8 = 1'b0;
        end
        @(negedge clk);
        check("done8", done8, 1);
        check("busy8_done", busy8, 0);
        check("diff8", diff8, ed);
        check("borrow8", borrow8, eb);
        exp_diff = ed;
        exp_borrow = eb;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_diff = 8'd0;
        exp_borrow = 1'b0;
        rst_n = 1'b0;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);
        rst_n = 1'b1;

        run8(8'd200, 8'd55, 0, 0, 8'd145, 1'b0);
        @(negedge clk);
        check("idle_after_done", done8, 0);
        check("idle_busy", busy8, 0);
        run8(8'd5, 8'd10, 0, 0, 8'hFB, 1'b1);
        run8(8'hA5, 8'hA5, 0, 0, 8'h00, 1'b0);
        run8(8'd200, 8'd55, 0, 1, 8'd145, 1'b0);
        @(negedge clk);
        check("hold_no_restart", busy8, 0);
        run8(8'd10, 8'd1, 0, 0, 8'd9, 1'b0);
        run8(8'd3, 8'd7, 1, 0, 8'd252, 1'b1);

        // Reset mid-operation.
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'd100;
        b8 = 8'd1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_diff", diff8, 0);
        check("midrst_borrow", borrow8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_diff = 8'd0;
        exp_borrow = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done8, 0);
            check("no_busy_after_rst", busy8, 0);
        end
        run8(8'd0, 8'd1, 0, 0, 8'hFF, 1'b1);

        // Exhaustive WIDTH=4 against an integer reference.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                start4 = 1'b1;
                a4 = x[3:0];
                b4 = y[3:0];
                @(posedge clk);
                #1 start4 = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("busy4", busy4, 1);
                    check("done4_early", done4, 0);
                end
                @(negedge clk);
                check("done4", done4, 1);
                check("diff4", diff4, (x - y) & 32'hF);
                check("borrow4", borrow4, (x < y) ? 1 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
